// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizing defaults and the writeback-source encoding for the
// register-file writeback arbiter and its pending-write scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int ADDR_W_DEF   = 3;
  localparam int DATA_W_DEF   = 8;
  localparam int CNT_W        = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Per-register pending-write counters: issue increments, committed write
// decrements, busy flags and a sticky underflow error for decode.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                issue_i,
  input  logic [ADDR_W-1:0]   issue_addr_i,
  input  logic                commit_i,
  input  logic [ADDR_W-1:0]   commit_addr_i,
  output logic                issue_ready_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                err_o
);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] under_vec;
  logic                issue_acc;
  logic                err_q;

  assign issue_ready_o = (cnt_q[issue_addr_i] != CNT_MAX);
  assign issue_acc     = issue_i & issue_ready_o;
  assign err_o         = err_q;

  // An issue and a commit to the same register cancel each other out.
  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    under_vec = '0;
    busy_o    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r]   = issue_acc && (issue_addr_i == ADDR_W'(r));
      dec_vec[r]   = commit_i && (commit_addr_i == ADDR_W'(r));
      under_vec[r] = dec_vec[r] && !inc_vec[r] && (cnt_q[r] == '0);
      busy_o[r]    = (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt_q[r] <= cnt_q[r] + 1'b1;
        end else if (dec_vec[r] && !inc_vec[r] && !under_vec[r]) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
      err_q <= err_q | (|under_vec);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of ALU and load writebacks onto the single
// register-file write port, with a registered output stage and scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                alu_valid_i,
  output logic                alu_ready_o,
  input  logic [ADDR_W-1:0]   alu_addr_i,
  input  logic [DATA_W-1:0]   alu_data_i,
  input  logic                alu_cb_we_i,
  input  logic                alu_cb_i,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic                write_o,
  output logic [ADDR_W-1:0]   write_addr_o,
  output logic [DATA_W-1:0]   write_data_o,
  output logic                write_cb_o,
  output logic                cb_data_o,
  input  logic                issue_i,
  input  logic [ADDR_W-1:0]   issue_addr_i,
  output logic                issue_ready_o,
  output logic [NUM_REGS-1:0] busy_o,
  output logic                err_o
);

  src_e               last_grant_q;
  logic               alu_gnt;
  logic               mem_gnt;
  logic               vld_p1;
  logic [ADDR_W-1:0]  addr_p1;
  logic [DATA_W-1:0]  data_p1;
  logic               cb_we_p1;
  logic               cb_data_p1;

  // Under contention the source that did not win last time takes the port.
  assign alu_gnt = alu_valid_i & (~mem_valid_i | (last_grant_q == SRC_MEM));
  assign mem_gnt = mem_valid_i & (~alu_valid_i | (last_grant_q == SRC_ALU));

  assign alu_ready_o = alu_gnt;
  assign mem_ready_o = mem_gnt;

  // Stage p1: registered regfile write port
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant_q <= SRC_MEM;
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
      cb_we_p1     <= 1'b0;
      cb_data_p1   <= 1'b0;
    end else begin
      vld_p1   <= alu_gnt | mem_gnt;
      cb_we_p1 <= alu_gnt & alu_cb_we_i;
      if (alu_gnt) begin
        last_grant_q <= SRC_ALU;
        addr_p1      <= alu_addr_i;
        data_p1      <= alu_data_i;
        if (alu_cb_we_i) cb_data_p1 <= alu_cb_i;
      end else if (mem_gnt) begin
        last_grant_q <= SRC_MEM;
        addr_p1      <= mem_addr_i;
        data_p1      <= mem_data_i;
      end
    end
  end

  assign write_o      = vld_p1;
  assign write_addr_o = addr_p1;
  assign write_data_o = data_p1;
  assign write_cb_o   = cb_we_p1;
  assign cb_data_o    = cb_data_p1;

  wb_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .issue_i       (issue_i),
    .issue_addr_i  (issue_addr_i),
    .commit_i      (vld_p1),
    .commit_addr_i (addr_p1),
    .issue_ready_o (issue_ready_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus a randomized run against a behavioural model of
// the writeback arbiter and pending-write scoreboard.
module tb_regfile_wb_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       alu_valid_i, alu_ready_o, alu_cb_we_i, alu_cb_i;
  logic [2:0] alu_addr_i, mem_addr_i, write_addr_o, issue_addr_i;
  logic [7:0] alu_data_i, mem_data_i, write_data_o, busy_o;
  logic       mem_valid_i, mem_ready_o;
  logic       write_o, write_cb_o, cb_data_o;
  logic       issue_i, issue_ready_o, err_o;

  int n_pass  = 0;
  int n_total = 0;

  // behavioural model state
  int         m_cnt [8];
  bit         m_err;
  bit         m_alu_won_last;
  bit         m_wv, m_wcb, m_cbd;
  logic [2:0] m_waddr;
  logic [7:0] m_wdata;

  always #5 clk_i = ~clk_i;

  regfile_wb_arbiter dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .alu_valid_i   (alu_valid_i),
    .alu_ready_o   (alu_ready_o),
    .alu_addr_i    (alu_addr_i),
    .alu_data_i    (alu_data_i),
    .alu_cb_we_i   (alu_cb_we_i),
    .alu_cb_i      (alu_cb_i),
    .mem_valid_i   (mem_valid_i),
    .mem_ready_o   (mem_ready_o),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .write_o       (write_o),
    .write_addr_o  (write_addr_o),
    .write_data_o  (write_data_o),
    .write_cb_o    (write_cb_o),
    .cb_data_o     (cb_data_o),
    .issue_i       (issue_i),
    .issue_addr_i  (issue_addr_i),
    .issue_ready_o (issue_ready_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  task automatic idle();
    alu_valid_i = 1'b0; alu_addr_i = '0; alu_data_i = '0;
    alu_cb_we_i = 1'b0; alu_cb_i = 1'b0;
    mem_valid_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    issue_i = 1'b0; issue_addr_i = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    idle();
    reset_n_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset_n_i = 1'b0;
    @(negedge clk_i);
    n_total++; if (write_o !== 1'b0) $display("FAIL rst_write: got %b want 0", write_o); else n_pass++;
    n_total++; if (write_cb_o !== 1'b0) $display("FAIL rst_write_cb: got %b want 0", write_cb_o); else n_pass++;
    n_total++; if (write_addr_o !== 3'd0) $display("FAIL rst_addr: got %h want 0", write_addr_o); else n_pass++;
    n_total++; if (write_data_o !== 8'h00) $display("FAIL rst_data: got %h want 00", write_data_o); else n_pass++;
    n_total++; if (cb_data_o !== 1'b0) $display("FAIL rst_cb_data: got %b want 0", cb_data_o); else n_pass++;
    n_total++; if (busy_o !== 8'h00) $display("FAIL rst_busy: got %h want 00", busy_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
    n_total++; if (issue_ready_o !== 1'b1) $display("FAIL rst_issue_ready: got %b want 1", issue_ready_o); else n_pass++;
    n_total++; if ({alu_ready_o, mem_ready_o} !== 2'b00) $display("FAIL rst_ready_idle: got %b want 00", {alu_ready_o, mem_ready_o}); else n_pass++;
    alu_valid_i = 1'b1;
    #1;
    n_total++; if (alu_ready_o !== 1'b1) $display("FAIL rst_ready_follow: got %b want 1", alu_ready_o); else n_pass++;
    idle();
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_alu_only();
    apply_reset();
    alu_valid_i = 1'b1; alu_addr_i = 3'd3; alu_data_i = 8'h5A;
    alu_cb_we_i = 1'b1; alu_cb_i = 1'b1;
    #1;
    n_total++; if ({alu_ready_o, mem_ready_o} !== 2'b10) $display("FAIL alu_ready: got %b want 10", {alu_ready_o, mem_ready_o}); else n_pass++;
    @(posedge clk_i); #1;
    idle();
    n_total++; if ({write_o, write_addr_o, write_data_o} !== {1'b1, 3'd3, 8'h5A})
      $display("FAIL alu_write: got %b/%h/%h want 1/3/5a", write_o, write_addr_o, write_data_o); else n_pass++;
    n_total++; if ({write_cb_o, cb_data_o} !== 2'b11) $display("FAIL alu_cb: got %b want 11", {write_cb_o, cb_data_o}); else n_pass++;
    @(posedge clk_i); #1;
    n_total++; if ({write_o, write_cb_o, write_addr_o, write_data_o} !== {2'b00, 3'd3, 8'h5A})
      $display("FAIL alu_hold: got %b%b/%h/%h want 00/3/5a", write_o, write_cb_o, write_addr_o, write_data_o); else n_pass++;
  endtask

  task automatic test_contention();
    apply_reset();
    alu_valid_i = 1'b1; alu_addr_i = 3'd1; alu_data_i = 8'h11; alu_cb_we_i = 1'b1; alu_cb_i = 1'b1;
    mem_valid_i = 1'b1; mem_addr_i = 3'd2; mem_data_i = 8'h22;
    for (int i = 0; i < 3; i++) begin
      bit alu_turn;
      alu_turn = (i != 1);
      #1;
      n_total++; if ({alu_ready_o, mem_ready_o} !== {alu_turn, !alu_turn})
        $display("FAIL cont_grant%0d: got %b want %b", i, {alu_ready_o, mem_ready_o}, {alu_turn, !alu_turn}); else n_pass++;
      @(posedge clk_i); #1;
      n_total++; if ({write_o, write_addr_o, write_data_o, write_cb_o} !== (alu_turn ? {1'b1, 3'd1, 8'h11, 1'b1} : {1'b1, 3'd2, 8'h22, 1'b0}))
        $display("FAIL cont_write%0d: got %b/%h/%h/%b", i, write_o, write_addr_o, write_data_o, write_cb_o); else n_pass++;
      @(negedge clk_i);
    end
    idle();
  endtask

  task automatic test_scoreboard();
    apply_reset();
    issue_i = 1'b1; issue_addr_i = 3'd5;
    #1;
    n_total++; if (issue_ready_o !== 1'b1) $display("FAIL sb_ready0: got %b want 1", issue_ready_o); else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i);
    issue_i = 1'b0;
    n_total++; if (busy_o !== 8'h20) $display("FAIL sb_busy2: got %h want 20", busy_o); else n_pass++;
    alu_valid_i = 1'b1; alu_addr_i = 3'd5; alu_data_i = 8'hA5;
    @(negedge clk_i);
    @(negedge clk_i);
    alu_valid_i = 1'b0;
    n_total++; if (busy_o !== 8'h20) $display("FAIL sb_busy_mid: got %h want 20", busy_o); else n_pass++;
    @(negedge clk_i);
    n_total++; if (busy_o !== 8'h00) $display("FAIL sb_busy_clear: got %h want 00", busy_o); else n_pass++;
    issue_i = 1'b1; issue_addr_i = 3'd5;
    repeat (3) @(negedge clk_i);
    #1;
    n_total++; if (issue_ready_o !== 1'b0) $display("FAIL sb_full: got %b want 0", issue_ready_o); else n_pass++;
    issue_addr_i = 3'd0;
    #1;
    n_total++; if (issue_ready_o !== 1'b1) $display("FAIL sb_other_ready: got %b want 1", issue_ready_o); else n_pass++;
    issue_addr_i = 3'd5;
    @(negedge clk_i);
    issue_i = 1'b0;
    n_total++; if (busy_o !== 8'h20) $display("FAIL sb_busy3: got %h want 20", busy_o); else n_pass++;
    alu_valid_i = 1'b1; alu_addr_i = 3'd5;
    repeat (3) @(negedge clk_i);
    alu_valid_i = 1'b0;
    n_total++; if (busy_o !== 8'h20) $display("FAIL sb_busy_left1: got %h want 20", busy_o); else n_pass++;
    @(negedge clk_i);
    n_total++; if ({busy_o, err_o} !== {8'h00, 1'b0}) $display("FAIL sb_drain: got %h/%b want 00/0", busy_o, err_o); else n_pass++;
  endtask

  task automatic test_same_cycle();
    apply_reset();
    issue_i = 1'b1; issue_addr_i = 3'd4;
    @(negedge clk_i);
    issue_i = 1'b0;
    mem_valid_i = 1'b1; mem_addr_i = 3'd4; mem_data_i = 8'h44;
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    issue_i = 1'b1; issue_addr_i = 3'd4;
    n_total++; if ({write_o, write_addr_o} !== {1'b1, 3'd4}) $display("FAIL same_write: got %b/%h want 1/4", write_o, write_addr_o); else n_pass++;
    @(negedge clk_i);
    issue_i = 1'b0;
    n_total++; if ({busy_o, err_o} !== {8'h10, 1'b0}) $display("FAIL same_busy: got %h/%b want 10/0", busy_o, err_o); else n_pass++;
    mem_valid_i = 1'b1;
    @(negedge clk_i);
    mem_valid_i = 1'b0;
    @(negedge clk_i);
    n_total++; if ({busy_o, err_o} !== {8'h00, 1'b0}) $display("FAIL same_drain: got %h/%b want 00/0", busy_o, err_o); else n_pass++;
  endtask

  task automatic test_err();
    apply_reset();
    alu_valid_i = 1'b1; alu_addr_i = 3'd6; alu_data_i = 8'h66;
    @(negedge clk_i);
    alu_valid_i = 1'b0;
    n_total++; if ({write_o, err_o} !== 2'b10) $display("FAIL err_before: got %b want 10", {write_o, err_o}); else n_pass++;
    @(negedge clk_i);
    n_total++; if ({err_o, busy_o} !== {1'b1, 8'h00}) $display("FAIL err_set: got %b/%h want 1/00", err_o, busy_o); else n_pass++;
    repeat (4) @(negedge clk_i);
    n_total++; if (err_o !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_o); else n_pass++;
    apply_reset();
    n_total++; if (err_o !== 1'b0) $display("FAIL err_reset: got %b want 0", err_o); else n_pass++;
  endtask

  task automatic test_reset_midop();
    apply_reset();
    issue_i = 1'b1; issue_addr_i = 3'd2;
    alu_valid_i = 1'b1; alu_addr_i = 3'd2; alu_data_i = 8'h77;
    @(negedge clk_i);
    idle();
    n_total++; if ({write_o, busy_o} !== {1'b1, 8'h04}) $display("FAIL mid_before: got %b/%h want 1/04", write_o, busy_o); else n_pass++;
    reset_n_i = 1'b0;
    #1;
    n_total++; if ({write_o, busy_o} !== {1'b0, 8'h00}) $display("FAIL mid_async: got %b/%h want 0/00", write_o, busy_o); else n_pass++;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    alu_valid_i = 1'b1; mem_valid_i = 1'b1;
    #1;
    n_total++; if ({alu_ready_o, mem_ready_o} !== 2'b10) $display("FAIL mid_first_grant: got %b want 10", {alu_ready_o, mem_ready_o}); else n_pass++;
    @(negedge clk_i);
    idle();
  endtask

  task automatic test_random();
    bit   exp_a, exp_m, exp_ir, inc;
    int   nxt;
    logic [7:0] exp_busy;
    apply_reset();
    for (int r = 0; r < 8; r++) m_cnt[r] = 0;
    m_err = 0; m_alu_won_last = 0;
    m_wv = 0; m_wcb = 0; m_cbd = 0; m_waddr = '0; m_wdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      alu_valid_i  = ($urandom_range(99) < 45);
      alu_addr_i   = 3'($urandom_range(7));
      alu_data_i   = 8'($urandom);
      alu_cb_we_i  = 1'($urandom);
      alu_cb_i     = 1'($urandom);
      mem_valid_i  = ($urandom_range(99) < 45);
      mem_addr_i   = 3'($urandom_range(7));
      mem_data_i   = 8'($urandom);
      issue_i      = ($urandom_range(99) < 70);
      issue_addr_i = 3'($urandom_range(7));
      #1;
      if (alu_valid_i && mem_valid_i) begin
        exp_a = !m_alu_won_last; exp_m = m_alu_won_last;
      end else begin
        exp_a = alu_valid_i; exp_m = mem_valid_i;
      end
      exp_ir = (m_cnt[issue_addr_i] < 3);
      n_total++; if ({alu_ready_o, mem_ready_o} !== {exp_a, exp_m})
        $display("FAIL rnd_grant@%0d: got %b want %b", cyc, {alu_ready_o, mem_ready_o}, {exp_a, exp_m}); else n_pass++;
      n_total++; if (issue_ready_o !== exp_ir)
        $display("FAIL rnd_issue_ready@%0d: got %b want %b", cyc, issue_ready_o, exp_ir); else n_pass++;
      @(posedge clk_i); #1;
      inc = issue_i && exp_ir;
      for (int r = 0; r < 8; r++) begin
        nxt = m_cnt[r] + ((inc && issue_addr_i == 3'(r)) ? 1 : 0) - ((m_wv && m_waddr == 3'(r)) ? 1 : 0);
        if (nxt < 0) begin
          nxt = 0; m_err = 1;
        end
        m_cnt[r] = nxt;
      end
      m_wv = exp_a || exp_m;
      m_wcb = exp_a && alu_cb_we_i;
      if (exp_a) begin
        m_waddr = alu_addr_i; m_wdata = alu_data_i; m_alu_won_last = 1;
        if (alu_cb_we_i) m_cbd = alu_cb_i;
      end else if (exp_m) begin
        m_waddr = mem_addr_i; m_wdata = mem_data_i; m_alu_won_last = 0;
      end
      for (int r = 0; r < 8; r++) exp_busy[r] = (m_cnt[r] != 0);
      n_total++; if (write_o !== m_wv) $display("FAIL rnd_write@%0d: got %b want %b", cyc, write_o, m_wv); else n_pass++;
      n_total++; if (write_addr_o !== m_waddr) $display("FAIL rnd_addr@%0d: got %h want %h", cyc, write_addr_o, m_waddr); else n_pass++;
      n_total++; if (write_data_o !== m_wdata) $display("FAIL rnd_data@%0d: got %h want %h", cyc, write_data_o, m_wdata); else n_pass++;
      n_total++; if ({write_cb_o, cb_data_o} !== {m_wcb, m_cbd})
        $display("FAIL rnd_cb@%0d: got %b want %b", cyc, {write_cb_o, cb_data_o}, {m_wcb, m_cbd}); else n_pass++;
      n_total++; if (busy_o !== exp_busy) $display("FAIL rnd_busy@%0d: got %h want %h", cyc, busy_o, exp_busy); else n_pass++;
      n_total++; if (err_o !== m_err) $display("FAIL rnd_err@%0d: got %b want %b", cyc, err_o, m_err); else n_pass++;
      @(negedge clk_i);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_only();
    test_contention();
    test_scoreboard();
    test_same_cycle();
    test_err();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
